// File: rtl/gpio_in_debounce.sv
// Pad-input conditioning ahead of gpio.gpio_in: 2-flop synchroniser, per-bit
// programmable debounce, rise/fall event capture and a small register window.

module gpio_deb_lane #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pin,
    input  logic             deb_en,
    input  logic [CNT_W-1:0] len_m1,
    output logic             sync_o,
    output logic             stable_o
);
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = pin;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (!deb_en) begin
            stable_d = sync2_q;
        end else if (sync2_q != stable_q) begin
            // >= so a window shortened mid-count commits on the very next cycle
            if (cnt_q >= len_m1) stable_d = sync2_q;
            else                 cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sync_o   = sync2_q;
    assign stable_o = stable_q;
endmodule

module gpio_in_debounce #(
    parameter int WIDTH       = 8,
    parameter int DEB_DEFAULT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin_in,
    input  logic [7:0]       address,
    input  logic [31:0]      write_data,
    output logic [31:0]      read_data,
    input  logic             we,
    input  logic             re,
    output logic [WIDTH-1:0] gpio_in,
    output logic             irq
);
    localparam logic [7:0] A_CTRL    = 8'h00;
    localparam logic [7:0] A_RISE_EN = 8'h04;
    localparam logic [7:0] A_FALL_EN = 8'h08;
    localparam logic [7:0] A_PENDING = 8'h0C;
    localparam logic [7:0] A_DEB_LEN = 8'h10;
    localparam logic [7:0] A_RAW     = 8'h14;

    logic             deb_en_q, deb_en_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [CNT_W-1:0] deb_len_q, deb_len_d;
    logic [CNT_W-1:0] len_m1;
    logic [WIDTH-1:0] sync2, stable, rise_evt, fall_evt;
    logic             unused_bits;

    // DEB_LEN of 0 behaves as a one-cycle window
    assign len_m1 = (deb_len_q == '0) ? '0 : deb_len_q - 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        gpio_deb_lane #(.CNT_W(CNT_W)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .pin      (pin_in[i]),
            .deb_en   (deb_en_q),
            .len_m1   (len_m1),
            .sync_o   (sync2[i]),
            .stable_o (stable[i])
        );
    end

    // Edges are seen one cycle after gpio_in moves, against the last-cycle copy
    assign rise_evt = (stable & ~prev_q) & rise_en_q;
    assign fall_evt = (~stable & prev_q) & fall_en_q;

    always_comb begin
        deb_en_d  = deb_en_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        deb_len_d = deb_len_q;
        pending_d = pending_q;
        prev_d    = stable;
        if (we) begin
            case (address)
                A_CTRL:    deb_en_d  = write_data[0];
                A_RISE_EN: rise_en_d = write_data[WIDTH-1:0];
                A_FALL_EN: fall_en_d = write_data[WIDTH-1:0];
                A_PENDING: pending_d = pending_q & ~write_data[WIDTH-1:0];
                A_DEB_LEN: deb_len_d = write_data[CNT_W-1:0];
                default: ;
            endcase
        end
        pending_d = pending_d | rise_evt | fall_evt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_en_q  <= 1'b1;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pending_q <= '0;
            prev_q    <= '0;
            deb_len_q <= CNT_W'(DEB_DEFAULT);
        end else begin
            deb_en_q  <= deb_en_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pending_q <= pending_d;
            prev_q    <= prev_d;
            deb_len_q <= deb_len_d;
        end
    end

    always_comb begin
        read_data = '0;
        case (address)
            A_CTRL:    read_data = 32'(deb_en_q);
            A_RISE_EN: read_data = 32'(rise_en_q);
            A_FALL_EN: read_data = 32'(fall_en_q);
            A_PENDING: read_data = 32'(pending_q);
            A_DEB_LEN: read_data = 32'(deb_len_q);
            A_RAW:     read_data = 32'(sync2);
            default:   read_data = '0;
        endcase
    end

    assign gpio_in     = stable;
    assign irq         = |(pending_q & (rise_en_q | fall_en_q));
    assign unused_bits = ^{re, write_data};
endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed plus random stimulus against a history-based reference model of the
// debouncer and its register window.
module tb_gpio_in_debounce;
    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst, we, re, irq;
    logic [W-1:0]  pin_in, gpio_in;
    logic [7:0]    address;
    logic [31:0]   write_data, read_data;

    gpio_in_debounce #(.WIDTH(W), .DEB_DEFAULT(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .pin_in(pin_in), .address(address),
        .write_data(write_data), .read_data(read_data), .we(we), .re(re),
        .gpio_in(gpio_in), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model state
    logic [W-1:0] m_s1, m_s2, m_stb, m_prev, m_pend, m_rise, m_fall;
    logic         m_en;
    logic [15:0]  m_len;
    // per bit: synchronised samples the debouncer has seen; -1 marks a bypass cycle
    int           hist[W][$];

    function automatic void model_edge(input logic [W-1:0] p, input logic r, input logic w,
                                       input logic [7:0] a, input logic [31:0] d);
        logic [W-1:0] nstb, npend, w1c;
        int eff, run;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_stb = '0; m_prev = '0; m_pend = '0;
            m_rise = '0; m_fall = '0; m_en = 1'b1; m_len = 16'd16;
            for (int b = 0; b < W; b++) hist[b].delete();
            return;
        end
        eff  = (m_len == 0) ? 1 : int'(m_len);
        nstb = m_stb;
        for (int b = 0; b < W; b++) begin
            if (!m_en) begin
                hist[b].push_back(-1);
                nstb[b] = m_s2[b];
            end else begin
                hist[b].push_back(int'(m_s2[b]));
                run = 0;
                // length of the trailing streak of samples disagreeing with the output
                for (int i = hist[b].size() - 1; i >= 0 && hist[b][i] == int'(!m_stb[b]); i--) run++;
                if (run >= eff) nstb[b] = m_s2[b];
            end
            if (hist[b].size() > 64) void'(hist[b].pop_front());
        end
        w1c   = (w && a == 8'h0C) ? d[W-1:0] : '0;
        npend = (m_pend & ~w1c) | (m_stb & ~m_prev & m_rise) | (~m_stb & m_prev & m_fall);
        m_prev = m_stb; m_stb = nstb; m_s2 = m_s1; m_s1 = p; m_pend = npend;
        if (w) begin
            case (a)
                8'h00: m_en   = d[0];
                8'h04: m_rise = d[W-1:0];
                8'h08: m_fall = d[W-1:0];
                8'h10: m_len  = d[15:0];
                default: ;
            endcase
        end
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a)
            8'h00:   return 32'(m_en);
            8'h04:   return 32'(m_rise);
            8'h08:   return 32'(m_fall);
            8'h0C:   return 32'(m_pend);
            8'h10:   return 32'(m_len);
            8'h14:   return 32'(m_s2);
            default: return 32'h0;
        endcase
    endfunction

    task automatic step();
        model_edge(pin_in, rst, we, address, write_data);
        @(posedge clk);
        #1;
        chk("gpio_in", 32'(gpio_in), 32'(m_stb));
        chk("irq", 32'(irq), 32'(|(m_pend & (m_rise | m_fall))));
        chk("read_data", read_data, m_read(address));
        we  = 1'b0;
        rst = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        address = a; write_data = d; we = 1'b1;
        step();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int lat, hi;
    logic saw;

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; pin_in = '0; address = 8'h00; write_data = '0;
        step(); rst = 1'b1; step();
        chk("ctrl_rst", read_data, 32'h1);
        chk("gpio_rst", 32'(gpio_in), 32'h0);
        address = 8'h10; step();
        chk("len_rst", read_data, 32'd16);

        // 16-cycle window: 2 sync + 16 debounce
        address = 8'h14; pin_in = 8'h01; lat = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            step();
            if (k == 1) chk("raw_1cyc", read_data, 32'h0);
            if (k == 2) chk("raw_2cyc", read_data, 32'h1);
            if (gpio_in[0]) lat = k;
        end
        chk("lat_18", 32'(lat), 32'd18);

        // glitch rejection and minimal pulse with a 4-cycle window
        wr(8'h10, 32'd4);
        pin_in = 8'h09; steps(3); pin_in = 8'h01; saw = 1'b0;
        for (int k = 0; k < 12; k++) begin step(); saw |= gpio_in[3]; end
        chk("glitch_gpio", 32'(saw), 32'h0);
        address = 8'h0C; step();
        chk("glitch_pend", read_data, 32'h0);
        pin_in = 8'h09; steps(4); pin_in = 8'h01; hi = 0;
        for (int k = 0; k < 14; k++) begin step(); if (gpio_in[3]) hi++; end
        chk("pulse_4", 32'(hi), 32'd4);

        // rise/fall events with W1C
        wr(8'h04, 32'h01); wr(8'h08, 32'h01);
        pin_in = 8'h00; steps(10);
        wr(8'h0C, 32'hFF);
        pin_in = 8'h01; steps(10);
        chk("rise_pend", read_data, 32'h01);
        chk("rise_irq", 32'(irq), 32'h1);
        wr(8'h0C, 32'h01);
        chk("w1c_pend", read_data, 32'h0);
        chk("w1c_irq", 32'(irq), 32'h0);
        pin_in = 8'h00; steps(10);
        chk("fall_pend", read_data, 32'h01);

        // event on bit 2 coinciding with its W1C: set wins
        wr(8'h08, 32'h0); wr(8'h04, 32'h04); wr(8'h0C, 32'hFF);
        pin_in = 8'h04; lat = -1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin step(); if (gpio_in[2]) lat = k; end
        chk("bit2_seen", 32'(lat), 32'd6);
        wr(8'h0C, 32'h04);
        chk("set_wins_pend", read_data & 32'h04, 32'h04);
        chk("set_wins_irq", 32'(irq), 32'h1);

        // bypass and DEB_LEN=0 both give a 3-cycle path
        wr(8'h00, 32'h0);
        pin_in = 8'hA5; lat = -1;
        for (int k = 1; k <= 10 && lat < 0; k++) begin step(); if (gpio_in == 8'hA5) lat = k; end
        chk("bypass_lat", 32'(lat), 32'd3);
        wr(8'h10, 32'h0); wr(8'h00, 32'h1);
        pin_in = 8'h5A; lat = -1;
        for (int k = 1; k <= 10 && lat < 0; k++) begin step(); if (gpio_in == 8'h5A) lat = k; end
        chk("len0_lat", 32'(lat), 32'd3);

        // reset in the middle of a debounce window
        wr(8'h10, 32'd16);
        pin_in = 8'h00; steps(25);
        pin_in = 8'h02; steps(12);
        rst = 1'b1; step();
        chk("rst_gpio", 32'(gpio_in), 32'h0);
        address = 8'h0C; #1 chk("rst_pend", read_data, 32'h0);
        address = 8'h10; #1 chk("rst_len", read_data, 32'd16);
        address = 8'h00; #1 chk("rst_ctrl", read_data, 32'h1);
        lat = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin step(); if (gpio_in[1]) lat = k; end
        chk("rst_relat", 32'(lat), 32'd18);

        // random traffic against the model
        wr(8'h10, 32'd3);
        for (int c = 0; c < 2000; c++) begin
            logic [7:0] addrs [8];
            addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h3C};
            if ($urandom_range(0, 3) == 0) pin_in[$urandom_range(0, W-1)] ^= 1'b1;
            address = addrs[$urandom_range(0, 7)];
            if ($urandom_range(0, 29) == 0) begin
                we = 1'b1;
                case (address)
                    8'h00:   write_data = ($urandom_range(0, 4) != 0) ? 32'h1 : 32'h0;
                    8'h10:   write_data = $urandom_range(0, 7);
                    default: write_data = $urandom;
                endcase
            end
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/gpio_in_debounce.md
Name: gpio_in_debounce

Overview:
- Input conditioning stage directly upstream of the gpio peripheral's gpio_in port.
- Synchronises raw pad inputs into clk and debounces each bit with a programmable stability window.
- Drives the clean value to gpio_in and raises per-bit rising/falling edge events with a level interrupt.
- Own memory-mapped register window on the peripheral bus; same address/we/re/read_data protocol as the other peripherals.

Parameters:
- WIDTH, 8, number of input bits.
- DEB_DEFAULT, 16, reset value of DEB_LEN (stability window in clk cycles).
- CNT_W, 16, width of DEB_LEN and the per-bit counters.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- pin_in  input  WIDTH  raw asynchronous pad inputs.
- address  input  8  byte offset within the block.
- write_data  input  32  bus write data.
- read_data  output  32  combinational read data.
- we  input  1  write strobe, one cycle per access.
- re  input  1  read strobe; reads have no side effects.
- gpio_in  output  WIDTH  debounced value, wired to gpio.gpio_in.
- irq  output  1  OR of (PENDING & (RISE_EN | FALL_EN)).

Behaviour:
- Register map (unused bits read 0; unmapped offsets read 0 and ignore writes):
  - 0x00 CTRL: bit0 DEB_EN (reset 1).
  - 0x04 RISE_EN[WIDTH-1:0] (reset 0).
  - 0x08 FALL_EN[WIDTH-1:0] (reset 0).
  - 0x0C PENDING[WIDTH-1:0], write-1-to-clear (reset 0).
  - 0x10 DEB_LEN[CNT_W-1:0] (reset DEB_DEFAULT).
  - 0x14 RAW: synchronised value, read-only.
- Synchroniser: two flops per bit (sync1, sync2), both reset to 0. A pin change is visible on sync2 two cycles later.
- Debounce, per bit, when DEB_EN=1:
  - Counter cnt, reset 0.
  - If sync2 == stable: cnt <= 0.
  - Else if cnt == eff_len-1: stable <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - eff_len = DEB_LEN, except DEB_LEN=0 is treated as 1.
  - A pin change held steady therefore reaches gpio_in 2+eff_len cycles after the edge. Any glitch shorter than eff_len cycles restarts the counter and never reaches gpio_in.
- Bypass (DEB_EN=0): stable <= sync2 every cycle, all cnt held at 0. Latency is 3 cycles pin-to-gpio_in.
- DEB_EN 1->0 mid-window: counters cleared; stable follows sync2 on the next cycle.
- DEB_LEN written mid-window: takes effect the next cycle. If cnt >= new eff_len-1, the bit updates on that next cycle.
- gpio_in = stable (registered), reset 0.
- Edge events, per bit: on the cycle stable changes 0->1 with RISE_EN set, or 1->0 with FALL_EN set, set PENDING the following cycle.
- Event and W1C on the same bit in the same cycle: the set wins.
- Events are not recorded while the corresponding enable is 0. Enabling later does not report past edges.
- irq is combinational from registers.
- Clearing the enable masks irq but does not clear PENDING.
- rst asserted at any time returns every register, counter, synchroniser flop and output to its reset value on the next clk edge. No event is generated by reset itself.
- Reset-exit rule: after reset, stable=0. A pin already held high produces a rising event (if enabled) once debounced.
- Writes use write_data only for the addressed register, take effect at the clk edge with we=1, and are ignored while rst=1.

Test Plan:
- Reset, DEB_LEN=16, pin_in[0] 0->1 held -> gpio_in[0] rises exactly 18 cycles after the pin edge. RAW[0] reads 1 after 2 cycles.
- DEB_LEN=4, 3-cycle high glitch on pin_in[3] -> gpio_in[3] stays 0, PENDING stays 0. A 4-cycle pulse -> gpio_in[3] high for 4 cycles.
- RISE_EN=0x01, FALL_EN=0x01, pin_in[0] 0->1->0 with long holds -> PENDING=0x01 after the rise, irq=1. W1C 0x01 -> PENDING=0, irq=0. Fall -> PENDING=0x01 again.
- Bit 2 rise event coincident with a W1C of 0x04 -> PENDING[2]=1 afterward, irq=1.
- CTRL=0, pin_in=0xA5 -> gpio_in=0xA5 3 cycles later. DEB_LEN=0 with CTRL=1 -> 3-cycle latency (treated as 1).
- Assert rst for one cycle mid-debounce (cnt=10) -> gpio_in=0, PENDING=0, DEB_LEN reads 16, CTRL reads 1. A held-high pin re-debounces fully: 18 cycles from rst release.
